// File: rtl/hex_parser_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hex_parser_pkg : shared constants for the ASCII hex byte parser      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package hex_parser_pkg;

   localparam logic [7:0] c_CR = 8'h0D;
   localparam logic [7:0] c_LF = 8'h0A;

   localparam logic [1:0] c_WAIT_HIGH = 2'd0;
   localparam logic [1:0] c_WAIT_LOW  = 2'd1;
   localparam logic [1:0] c_WAIT_TERM = 2'd2;
   localparam logic [1:0] c_DISCARD   = 2'd3;

   localparam logic [1:0] c_ERR_NONE    = 2'd0;
   localparam logic [1:0] c_ERR_BAD     = 2'd1;
   localparam logic [1:0] c_ERR_EARLY   = 2'd2;
   localparam logic [1:0] c_ERR_TIMEOUT = 2'd3;

   function automatic logic is_terminator(input logic [7:0] ch);
      return (ch == c_CR) || (ch == c_LF);
   endfunction

endpackage
`default_nettype wire

// File: rtl/hex_char_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hex_char_decode : ASCII character to hex nibble, case-insensitive    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module hex_char_decode
   import hex_parser_pkg::*;
(
   input  logic [7:0] char_in,
   output logic [3:0] nibble,
   output logic       is_hex
);

   // Clearing bit 5 folds lowercase a-f onto A-F.
   logic [7:0] w_upper;
   assign w_upper = char_in & 8'hDF;

   always_comb begin
      nibble = 4'h0;
      is_hex = 1'b0;
      if (char_in >= 8'h30 && char_in <= 8'h39) begin
         nibble = char_in[3:0];
         is_hex = 1'b1;
      end else if (w_upper >= 8'h41 && w_upper <= 8'h46) begin
         nibble = char_in[3:0] + 4'd9;
         is_hex = 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/hex_byte_parser.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hex_byte_parser : parses "HH<CR|LF>" commands into a byte value      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module hex_byte_parser
   import hex_parser_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       new_rx_data,
   output logic [7:0] value,
   output logic       new_value,
   output logic       parse_error,
   output logic [1:0] err_code
);

   localparam int             CW        = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0]  c_LIMIT   = CW'(TIMEOUT_CYCLES);
   localparam logic [CW-1:0]  c_CNT_MAX = '1;

   logic [1:0]    r_state;
   logic [3:0]    r_high;
   logic [3:0]    r_low;
   logic [CW-1:0] r_cnt;
   logic [7:0]    r_value;
   logic          r_new_value;
   logic          r_parse_error;
   logic [1:0]    r_err_code;

   logic [3:0]    w_nibble;
   logic          w_is_hex;
   logic          w_is_term;
   logic          w_waiting;
   logic [CW-1:0] w_cnt_inc;
   logic          w_timeout;

   hex_char_decode u_decode (
      .char_in (rx_data),
      .nibble  (w_nibble),
      .is_hex  (w_is_hex)
   );

   assign w_is_term = is_terminator(rx_data);
   assign w_waiting = (r_state == c_WAIT_LOW) || (r_state == c_WAIT_TERM);
   assign w_cnt_inc = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + 1'b1;
   // A byte in the expiry cycle wins: the timeout is only considered when idle.
   assign w_timeout = (TIMEOUT_CYCLES != 0) && w_waiting && !new_rx_data && (w_cnt_inc == c_LIMIT);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= c_WAIT_HIGH;
         r_high        <= 4'h0;
         r_low         <= 4'h0;
         r_cnt         <= '0;
         r_value       <= 8'h00;
         r_new_value   <= 1'b0;
         r_parse_error <= 1'b0;
         r_err_code    <= c_ERR_NONE;
      end else begin
         r_new_value   <= 1'b0;
         r_parse_error <= 1'b0;
         if (new_rx_data) begin
            r_cnt <= '0;
            case (r_state)
               c_WAIT_HIGH: begin
                  if (w_is_hex) begin
                     r_high  <= w_nibble;
                     r_state <= c_WAIT_LOW;
                  end else if (!w_is_term) begin
                     r_parse_error <= 1'b1;
                     r_err_code    <= c_ERR_BAD;
                     r_state       <= c_DISCARD;
                  end
               end
               c_WAIT_LOW: begin
                  if (w_is_hex) begin
                     r_low   <= w_nibble;
                     r_state <= c_WAIT_TERM;
                  end else if (w_is_term) begin
                     r_parse_error <= 1'b1;
                     r_err_code    <= c_ERR_EARLY;
                     r_state       <= c_WAIT_HIGH;
                  end else begin
                     r_parse_error <= 1'b1;
                     r_err_code    <= c_ERR_BAD;
                     r_state       <= c_DISCARD;
                  end
               end
               c_WAIT_TERM: begin
                  if (w_is_term) begin
                     r_value     <= {r_high, r_low};
                     r_new_value <= 1'b1;
                     r_state     <= c_WAIT_HIGH;
                  end else begin
                     r_parse_error <= 1'b1;
                     r_err_code    <= c_ERR_BAD;
                     r_state       <= c_DISCARD;
                  end
               end
               default: begin
                  if (w_is_term)
                     r_state <= c_WAIT_HIGH;
               end
            endcase
         end else if (w_timeout) begin
            r_parse_error <= 1'b1;
            r_err_code    <= c_ERR_TIMEOUT;
            r_state       <= c_WAIT_HIGH;
            r_high        <= 4'h0;
            r_low         <= 4'h0;
            r_cnt         <= '0;
         end else if (w_waiting) begin
            r_cnt <= w_cnt_inc;
         end
      end
   end

   assign value       = r_value;
   assign new_value   = r_new_value;
   assign parse_error = r_parse_error;
   assign err_code    = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_hex_byte_parser.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_hex_byte_parser : directed self-checking bench for hex_byte_parser|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_hex_byte_parser;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] rx_data = 8'h00;
   logic       new_rx_data = 1'b0;
   logic [7:0] value;
   logic       new_value;
   logic       parse_error;
   logic [1:0] err_code;

   int n_assert = 0;
   int n_fail   = 0;
   int nv_cnt   = 0;
   int pe_cnt   = 0;
   logic both_seen = 1'b0;

   hex_byte_parser #(.TIMEOUT_CYCLES(100)) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_data     (rx_data),
      .new_rx_data (new_rx_data),
      .value       (value),
      .new_value   (new_value),
      .parse_error (parse_error),
      .err_code    (err_code)
   );

   always #5 clk = ~clk;

   // Pulse counters see the previous cycle's outputs at each rising edge.
   always @(posedge clk) begin
      if (new_value)   nv_cnt <= nv_cnt + 1;
      if (parse_error) pe_cnt <= pe_cnt + 1;
      if (new_value && parse_error) both_seen <= 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Returns on the falling edge after the sampling edge, so outputs are settled.
   task automatic send(input logic [7:0] b);
      @(negedge clk);
      rx_data     = b;
      new_rx_data = 1'b1;
      @(negedge clk);
      new_rx_data = 1'b0;
      rx_data     = 8'h00;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_counts();
      idle(2);
      nv_cnt = 0;
      pe_cnt = 0;
   endtask

   initial begin
      idle(3);
      rst = 1'b0;
      check("reset value", value, 8'h00);
      check("reset new_value", new_value, 1'b0);
      check("reset parse_error", parse_error, 1'b0);
      check("reset err_code", err_code, 2'd0);

      clear_counts();
      send("3"); send("F");
      check("3F before CR", new_value, 1'b0);
      send(8'h0D);
      check("3F new_value", new_value, 1'b1);
      check("3F value", value, 8'h3F);
      idle(1);
      check("3F pulse width", new_value, 1'b0);
      idle(1);
      check("3F nv count", nv_cnt, 1);
      check("3F pe count", pe_cnt, 0);

      clear_counts();
      send("a"); send("5"); send(8'h0D); send(8'h0A);
      check("a5 value", value, 8'hA5);
      idle(2);
      check("a5 nv count", nv_cnt, 1);
      check("a5 pe count", pe_cnt, 0);

      clear_counts();
      send("G");
      check("G error", parse_error, 1'b1);
      check("G code", err_code, 2'd1);
      send("1"); send("2"); send(8'h0A);
      check("discard value", value, 8'hA5);
      send("1"); send("2"); send(8'h0A);
      check("12 value", value, 8'h12);
      idle(2);
      check("G pe count", pe_cnt, 1);
      check("G nv count", nv_cnt, 1);

      clear_counts();
      send("7"); send(8'h0D);
      check("early error", parse_error, 1'b1);
      check("early code", err_code, 2'd2);
      check("early value held", value, 8'h12);
      send("C"); send("d"); send(8'h0D);
      check("Cd value", value, 8'hCD);
      idle(2);
      check("early pe count", pe_cnt, 1);
      check("early nv count", nv_cnt, 1);

      clear_counts();
      send("1"); send("2"); send("3");
      check("third digit code", err_code, 2'd1);
      send(8'h0D);
      send("@");
      check("at-sign error", parse_error, 1'b1);
      send(8'h0A);
      send("1"); send(":");
      check("colon error", parse_error, 1'b1);
      send(8'h0D);
      send("0"); send("f"); send(8'h0D);
      check("0f value", value, 8'h0F);
      idle(2);
      check("bad chars pe count", pe_cnt, 3);
      check("bad chars nv count", nv_cnt, 1);

      clear_counts();
      send("4");
      idle(99);
      check("timeout not yet", parse_error, 1'b0);
      idle(1);
      check("timeout fires", parse_error, 1'b1);
      check("timeout code", err_code, 2'd3);
      send("5"); send("5"); send(8'h0D);
      check("55 value", value, 8'h55);
      idle(2);
      check("timeout pe count", pe_cnt, 1);

      clear_counts();
      send("4");
      idle(98);
      send("1");
      check("byte beats timeout", parse_error, 1'b0);
      send(8'h0D);
      check("41 value", value, 8'h41);
      idle(2);
      check("race pe count", pe_cnt, 0);

      clear_counts();
      send("9"); send("9");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      send(8'h0D);
      check("rst new_value", new_value, 1'b0);
      check("rst parse_error", parse_error, 1'b0);
      check("rst value", value, 8'h00);
      check("rst err_code", err_code, 2'd0);
      idle(2);
      check("rst nv count", nv_cnt, 0);
      check("rst pe count", pe_cnt, 0);

      check("never both strobes", both_seen, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
